// File: rtl/tt_ram_pkg.sv
// Shared definitions for the two-requester RAM arbiter.
//   ADDR_BITS / NUM_BYTES / DATA_BITS : geometry of the shared byte RAM
//   OWNER_A / OWNER_B                 : encoding of which requester owns an access
//   issue_t                           : one in-flight access held in the issue register
//   addr_in_range()                   : true when an address hits a populated byte
package tt_ram_pkg;

    localparam int ADDR_BITS = 6;
    localparam int NUM_BYTES = 48;
    localparam int DATA_BITS = 8;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    typedef struct packed {
        logic                 vld;
        logic                 owner;
        logic                 we;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] wdata;
    } issue_t;

    function automatic logic addr_in_range(input logic [ADDR_BITS-1:0] addr);
        return 32'(addr) < 32'(NUM_BYTES);
    endfunction

endpackage

// File: rtl/tt_rr_pick2.sv
// Two-way round-robin picker, purely combinational.
//   req[0] = A request, req[1] = B request
//   last   = owner of the most recent grant (OWNER_A / OWNER_B)
//   gnt    = one-hot grant (or zero when nobody requests)
// On a tie the side that did not win last time is chosen.
module tt_rr_pick2
    import tt_ram_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == OWNER_B) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/tt_ram_arbiter.sv
// Arbiter sharing one single-port 48 x 8 RAM between requesters A and B.
//   clk, rst_n              : clock, asynchronous active-low reset
//   a_* / b_*               : requester ports (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   mem_addr/mem_we/mem_wdata : RAM command bus, driven from the issue register
//   mem_rdata               : RAM combinational read data for mem_addr
//
// Handshake: a requester raises req with we/addr/wdata stable and holds them
// until gnt (combinational, same cycle). A grant in cycle N is issued to the
// RAM in N+1; reads return in N+2 as a one-cycle rvalid pulse to the owner.
// A request may be withdrawn before it is granted.
module tt_ram_arbiter
    import tt_ram_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDR_BITS-1:0] a_addr,
    input  logic [DATA_BITS-1:0] a_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [DATA_BITS-1:0] a_rdata,

    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDR_BITS-1:0] b_addr,
    input  logic [DATA_BITS-1:0] b_wdata,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [DATA_BITS-1:0] b_rdata,

    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_we,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata
);

    logic [1:0]           gnt;
    logic                 last_gnt_q, last_gnt_d;
    issue_t               issue_q, issue_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 a_rvalid_q, a_rvalid_d;
    logic                 b_rvalid_q, b_rvalid_d;
    logic                 issue_in_range;
    logic                 issue_is_read;

    tt_rr_pick2 u_pick (
        .req  ({b_req, a_req}),
        .last (last_gnt_q),
        .gnt  (gnt)
    );

    assign a_gnt = gnt[0];
    assign b_gnt = gnt[1];

    assign issue_in_range = addr_in_range(issue_q.addr);
    assign issue_is_read  = issue_q.vld & ~issue_q.we;

    // Issue stage: capture the granted command. With no grant the previous
    // address/data are kept on the RAM bus and only vld drops.
    always_comb begin
        issue_d     = issue_q;
        issue_d.vld = 1'b0;
        last_gnt_d  = last_gnt_q;
        if (gnt[1]) begin
            issue_d.vld   = 1'b1;
            issue_d.owner = OWNER_B;
            issue_d.we    = b_we;
            issue_d.addr  = b_addr;
            issue_d.wdata = b_wdata;
            last_gnt_d    = OWNER_B;
        end else if (gnt[0]) begin
            issue_d.vld   = 1'b1;
            issue_d.owner = OWNER_A;
            issue_d.we    = a_we;
            issue_d.addr  = a_addr;
            issue_d.wdata = a_wdata;
            last_gnt_d    = OWNER_A;
        end
    end

    // Return stage: out-of-range reads return zero; rdata holds otherwise.
    always_comb begin
        rdata_d    = rdata_q;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        if (issue_is_read) begin
            rdata_d    = issue_in_range ? mem_rdata : '0;
            a_rvalid_d = (issue_q.owner == OWNER_A);
            b_rvalid_d = (issue_q.owner == OWNER_B);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= OWNER_B;
            issue_q    <= '0;
            rdata_q    <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
            issue_q    <= issue_d;
            rdata_q    <= rdata_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    // issue_q is cleared by reset, so mem_we is low throughout reset.
    assign mem_addr  = issue_q.addr;
    assign mem_wdata = issue_q.wdata;
    assign mem_we    = issue_q.vld & issue_q.we & issue_in_range;

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = rdata_q;
    assign b_rdata  = rdata_q;

endmodule

// File: tb/tb_tt_ram_arbiter.sv
module tb_tt_ram_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_req, a_we, a_gnt, a_rvalid;
  logic [5:0] a_addr;
  logic [7:0] a_wdata, a_rdata;
  logic       b_req, b_we, b_gnt, b_rvalid;
  logic [5:0] b_addr;
  logic [7:0] b_wdata, b_rdata;
  logic [5:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata, mem_rdata;

  int n_checks;
  int n_pass;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT ----------------
  tt_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // ---------------- RAM model: 48 populated bytes, ram[i] = i ^ 0x5A ----------------
  logic [7:0] ram [0:63];
  initial begin
    for (int i = 0; i < 64; i++) ram[i] <= 8'(i) ^ 8'h5A;
  end
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end
  // Unpopulated addresses float to a marker the arbiter must not pass on.
  assign mem_rdata = (int'(mem_addr) < 48) ? ram[mem_addr] : 8'hEE;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
  endtask

  task automatic drive_a(input logic we, input logic [5:0] addr, input logic [7:0] wd);
    a_req = 1; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic drive_b(input logic we, input logic [5:0] addr, input logic [7:0] wd);
    b_req = 1; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n = 0;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst_n = 1;
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] a_tab [0:3];
  logic [5:0] b_tab [0:2];
  logic [7:0] ret_data [0:5];
  int pulses;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 0;
    idle_inputs();
    repeat (2) next_cycle();
    rst_n = 1;

    // reset state
    sample();
    check("rst_a_rvalid", a_rvalid, 0);
    check("rst_b_rvalid", b_rvalid, 0);
    check("rst_rdata", a_rdata, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);

    // 1: A write 0x05 <- 0xA5, then A read 0x05
    next_cycle(); drive_a(1, 6'h05, 8'hA5);
    sample();
    check("t1_wr_a_gnt", a_gnt, 1);
    check("t1_wr_b_gnt", b_gnt, 0);
    next_cycle(); idle_inputs();
    sample();
    check("t1_mem_we", mem_we, 1);
    check("t1_mem_addr", mem_addr, 6'h05);
    check("t1_mem_wdata", mem_wdata, 8'hA5);
    next_cycle(); drive_a(0, 6'h05, 8'h00);
    sample();
    check("t1_rd_a_gnt", a_gnt, 1);
    check("t1_wr_no_rvalid", a_rvalid, 0);
    next_cycle(); idle_inputs();
    sample();
    check("t1_rd_mem_we", mem_we, 0);
    check("t1_rd_n1_rvalid", a_rvalid, 0);
    next_cycle();
    sample();
    check("t1_a_rvalid", a_rvalid, 1);
    check("t1_a_rdata", a_rdata, 8'hA5);
    check("t1_b_rvalid", b_rvalid, 0);
    next_cycle();
    sample();
    check("t1_rvalid_pulse", a_rvalid, 0);
    check("t1_rdata_hold", a_rdata, 8'hA5);

    // 2: both sides read every cycle for 6 cycles, starting from reset (A wins first tie)
    do_reset();
    a_tab[0] = 6'h01; a_tab[1] = 6'h02; a_tab[2] = 6'h03; a_tab[3] = 6'h00;
    b_tab[0] = 6'h14; b_tab[1] = 6'h15; b_tab[2] = 6'h16;
    ret_data[0] = 8'h5B; ret_data[1] = 8'h4E; ret_data[2] = 8'h58;
    ret_data[3] = 8'h4F; ret_data[4] = 8'h59; ret_data[5] = 8'h4C;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next_cycle();
      idle_inputs();
      if (k < 6) begin
        drive_a(0, a_tab[(k + 1) / 2], 8'h00);
        drive_b(0, b_tab[k / 2], 8'h00);
      end
      sample();
      if (k < 6) begin
        check($sformatf("t2_a_gnt_%0d", k), a_gnt, (k % 2 == 0) ? 1 : 0);
        check($sformatf("t2_b_gnt_%0d", k), b_gnt, (k % 2 == 1) ? 1 : 0);
      end
      if (k >= 2) begin
        check($sformatf("t2_a_rvalid_%0d", k), a_rvalid, (k % 2 == 0) ? 1 : 0);
        check($sformatf("t2_b_rvalid_%0d", k), b_rvalid, (k % 2 == 1) ? 1 : 0);
        check($sformatf("t2_rdata_%0d", k), a_rdata, ret_data[k - 2]);
      end
    end

    // 3: RAW - A write 0x10 <- 0x3C, B read 0x10 the next cycle
    next_cycle(); idle_inputs(); drive_a(1, 6'h10, 8'h3C);
    sample();
    check("t3_a_gnt", a_gnt, 1);
    next_cycle(); idle_inputs(); drive_b(0, 6'h10, 8'h00);
    sample();
    check("t3_b_gnt", b_gnt, 1);
    next_cycle(); idle_inputs();
    sample();
    check("t3_no_rvalid_wr", b_rvalid, 0);
    next_cycle();
    sample();
    check("t3_b_rvalid", b_rvalid, 1);
    check("t3_b_rdata", b_rdata, 8'h3C);

    // 4: out-of-range write then read at 0x30
    pulses = 0;
    next_cycle(); idle_inputs(); drive_b(1, 6'h30, 8'hFF);
    sample();
    check("t4_wr_b_gnt", b_gnt, 1);
    if (b_rvalid) pulses++;
    next_cycle(); drive_b(0, 6'h30, 8'h00);
    sample();
    check("t4_rd_b_gnt", b_gnt, 1);
    check("t4_mem_we_wr", mem_we, 0);
    if (b_rvalid) pulses++;
    next_cycle(); idle_inputs();
    sample();
    check("t4_mem_we_rd", mem_we, 0);
    if (b_rvalid) pulses++;
    next_cycle();
    sample();
    check("t4_b_rvalid", b_rvalid, 1);
    check("t4_b_rdata", b_rdata, 8'h00);
    if (b_rvalid) pulses++;
    next_cycle();
    sample();
    if (b_rvalid) pulses++;
    check("t4_pulses", pulses, 1);

    // 5: read 0x2F in flight, reset pulsed at N+1
    next_cycle(); drive_a(0, 6'h2F, 8'h00);
    sample();
    check("t5_a_gnt", a_gnt, 1);
    next_cycle(); idle_inputs(); rst_n = 0;
    sample();
    check("t5_rst_mem_we", mem_we, 0);
    check("t5_rst_mem_addr", mem_addr, 0);
    next_cycle(); rst_n = 1;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      sample();
      if (a_rvalid || b_rvalid) pulses++;
      next_cycle();
    end
    check("t5_no_rvalid", pulses, 0);
    check("t5_rdata", a_rdata, 0);
    drive_a(0, 6'h00, 8'h00); drive_b(0, 6'h00, 8'h00);
    sample();
    check("t5_tie_a_gnt", a_gnt, 1);
    check("t5_tie_b_gnt", b_gnt, 0);

    // 6: B held 10 cycles against continuous A; A just won, so B goes first
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      sample();
      check($sformatf("t6_b_gnt_%0d", k), b_gnt, (k % 2 == 0) ? 1 : 0);
      check($sformatf("t6_a_gnt_%0d", k), a_gnt, (k % 2 == 1) ? 1 : 0);
    end
    next_cycle(); idle_inputs();
    sample();
    check("t6_idle_gnt", {a_gnt, b_gnt}, 2'b00);
    repeat (3) next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
